// File: rtl/vectadd_pkg.sv
// Shared codes, state encoding and helpers for the vectadd engine.
// Command/status codes mirror the to_hw_sig / from_hw_sig PIO contract.
package vectadd_pkg;

  localparam logic [1:0] CMD_RELEASE = 2'd0;
  localparam logic [1:0] CMD_VALID   = 2'd1;
  localparam logic [1:0] CMD_RACK    = 2'd2;
  localparam logic [1:0] CMD_ABORT   = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_RVALID = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    SEND,
    DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vectadd_lane_add.sv
// Combinational DW-bit lane adder: a, b -> sum.
// VECTADD_SATURATE_EN selects signed saturation; default wraps mod 2^DW.
module vectadd_lane_add #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);

`ifdef VECTADD_SATURATE_EN
  logic [DW-1:0] raw;
  logic          ovf_pos;
  logic          ovf_neg;

  assign raw = a + b;
  // Overflow only when both operands share a sign the result lacks.
  assign ovf_pos = ~a[DW-1] & ~b[DW-1] & raw[DW-1];
  assign ovf_neg = a[DW-1] & b[DW-1] & ~raw[DW-1];

  always_comb begin
    sum = raw;
    if (ovf_pos) sum = {1'b0, {(DW-1){1'b1}}};
    if (ovf_neg) sum = {1'b1, {(DW-1){1'b0}}};
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/vectadd_hw_engine.sv
// Vector add engine: loads A then B over a 4-phase PIO handshake, adds,
// returns results. Ports: clk, reset_n, to_hw_data/sig in,
// from_hw_data/sig, busy out. Option macro: VECTADD_SATURATE_EN.
module vectadd_hw_engine
  import vectadd_pkg::*;
#(
  parameter int VLEN = 8,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] to_hw_data,
  input  logic [1:0]    to_hw_sig,
  output logic [DW-1:0] from_hw_data,
  output logic [1:0]    from_hw_sig,
  output logic          busy
);

  localparam int IDXW = idx_width(VLEN);
  localparam logic [IDXW-1:0] LAST = IDXW'(VLEN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_nxt;
  logic [1:0]      ph;
  logic [1:0]      ph_nxt;
  logic [DW-1:0]   data_nxt;
  logic [1:0]      sig_nxt;
  logic            busy_nxt;
  logic            wr_a;
  logic            wr_b;
  logic            wr_r;

  logic [DW-1:0] a_buf [VLEN];
  logic [DW-1:0] b_buf [VLEN];
  logic [DW-1:0] r_buf [VLEN];
  logic [DW-1:0] sum;

  vectadd_lane_add #(
    .DW (DW)
  ) u_add (
    .a   (a_buf[idx]),
    .b   (b_buf[idx]),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      ph           <= '0;
      from_hw_data <= '0;
      from_hw_sig  <= ST_IDLE;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      ph           <= ph_nxt;
      from_hw_data <= data_nxt;
      from_hw_sig  <= sig_nxt;
      busy         <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) a_buf[idx] <= to_hw_data;
    if (wr_b) b_buf[idx] <= to_hw_data;
    if (wr_r) r_buf[idx] <= sum;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ph_nxt    = ph;
    data_nxt  = from_hw_data;
    sig_nxt   = from_hw_sig;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_r      = 1'b0;
    if (to_hw_sig == CMD_ABORT) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      ph_nxt    = '0;
      data_nxt  = '0;
      sig_nxt   = ST_IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          sig_nxt = ST_IDLE;
          if (to_hw_sig == CMD_RELEASE) begin
            state_nxt = LOAD_A;
            idx_nxt   = '0;
            ph_nxt    = '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (ph == 2'd0 && to_hw_sig == CMD_VALID) begin
            wr_a    = (state == LOAD_A);
            wr_b    = (state == LOAD_B);
            sig_nxt = ST_ACCEPT;
            ph_nxt  = 2'd1;
          end else if (ph == 2'd1 &&
                       to_hw_sig == CMD_RELEASE) begin
            sig_nxt = ST_IDLE;
            ph_nxt  = 2'd0;
            if (idx == LAST) begin
              idx_nxt   = '0;
              state_nxt = (state == LOAD_A) ? LOAD_B
                                            : COMPUTE;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          wr_r = 1'b1;
          if (idx == LAST) begin
            idx_nxt   = '0;
            ph_nxt    = '0;
            state_nxt = SEND;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        SEND: begin
          unique case (ph)
            2'd0: begin
              data_nxt = r_buf[idx];
              sig_nxt  = ST_RVALID;
              ph_nxt   = 2'd1;
            end
            2'd1: begin
              if (to_hw_sig == CMD_RACK) begin
                sig_nxt = ST_IDLE;
                ph_nxt  = 2'd2;
              end
            end
            2'd2: begin
              if (to_hw_sig == CMD_RELEASE) begin
                ph_nxt = 2'd0;
                if (idx == LAST) begin
                  state_nxt = DONE;
                  sig_nxt   = ST_DONE;
                end else begin
                  idx_nxt = idx + 1'b1;
                end
              end
            end
            default: ph_nxt = 2'd0;
          endcase
        end
        DONE: sig_nxt = ST_DONE;
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == COMPUTE) ||
               (state_nxt == SEND);
  end

endmodule

// File: tb/tb_vectadd_hw_engine.sv
// Directed + random bench for vectadd_hw_engine with VLEN=4.
// Expected sums come from a plain-arithmetic reference function.
module tb_vectadd_hw_engine;
  import vectadd_pkg::*;

  localparam int VLEN = 4;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] to_hw_data;
  logic [1:0]    to_hw_sig;
  logic [DW-1:0] from_hw_data;
  logic [1:0]    from_hw_sig;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] va  [VLEN];
  logic [31:0] vb  [VLEN];
  logic [31:0] exp_r [VLEN];

  always #5 clk = ~clk;

  vectadd_hw_engine #(
    .VLEN (VLEN),
    .DW   (DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .to_hw_data   (to_hw_data),
    .to_hw_sig    (to_hw_sig),
    .from_hw_data (from_hw_data),
    .from_hw_sig  (from_hw_sig),
    .busy         (busy)
  );

  function automatic logic [31:0] ref_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint s;
`ifdef VECTADD_SATURATE_EN
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    s = longint'(a) + longint'(b);
    return s[31:0];
`endif
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_sig(
    input logic [1:0] exp,
    input string      tag
  );
    int k = 0;
    while (from_hw_sig !== exp && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(from_hw_sig), 32'(exp));
  endtask

  task automatic send_word(
    input logic [31:0] d,
    input bit          last
  );
    to_hw_data = d;
    to_hw_sig  = CMD_VALID;
    wait_sig(ST_ACCEPT, "accept");
    to_hw_sig = CMD_RELEASE;
    if (!last) wait_sig(ST_IDLE, "release");
  endtask

  task automatic compute_exp();
    for (int i = 0; i < VLEN; i++)
      exp_r[i] = ref_add(va[i], vb[i]);
  endtask

  task automatic run_load(input bit held_first);
    int s0 = 0;
    if (held_first) begin
      to_hw_data = va[0];
      to_hw_sig  = CMD_VALID;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("held_accept", 32'(from_hw_sig),
              32'(ST_ACCEPT));
        to_hw_data = $urandom;
      end
      to_hw_sig = CMD_RELEASE;
      wait_sig(ST_IDLE, "held_release");
      s0 = 1;
    end
    for (int i = s0; i < VLEN; i++) send_word(va[i], 1'b0);
    for (int i = 0; i < VLEN; i++)
      send_word(vb[i], i == VLEN - 1);
  endtask

  task automatic latency_check();
    int cyc  = 0;
    int bcnt = 0;
    check("busy_load", 32'(busy), 32'd0);
    while (from_hw_sig !== ST_RVALID && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    check("latency", 32'(cyc), 32'(VLEN + 2));
    check("busy_span", 32'(bcnt), 32'(VLEN + 2));
    @(negedge clk);
  endtask

  task automatic recv_one(input int i);
    wait_sig(ST_RVALID, "rvalid");
    check($sformatf("result%0d", i), from_hw_data,
          exp_r[i]);
    check("busy_send", 32'(busy), 32'd1);
    to_hw_sig = CMD_RACK;
    wait_sig(ST_IDLE, "rack");
    to_hw_sig = CMD_RELEASE;
    if (i == VLEN - 1) begin
      wait_sig(ST_DONE, "done");
      check("done_data", from_hw_data, exp_r[i]);
      check("busy_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic full_run(input bit held_first);
    compute_exp();
    run_load(held_first);
    latency_check();
    for (int i = 0; i < VLEN; i++) recv_one(i);
  endtask

  task automatic abort_seq();
    to_hw_sig = CMD_ABORT;
    @(negedge clk);
    check("abort_sig", 32'(from_hw_sig), 32'(ST_IDLE));
    check("abort_data", from_hw_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    to_hw_sig = CMD_RELEASE;
    @(negedge clk);
    check("restart_state", 32'(dut.state),
          32'(LOAD_A));
  endtask

  initial begin
    reset_n    = 1'b0;
    to_hw_sig  = CMD_RELEASE;
    to_hw_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sig", 32'(from_hw_sig), 32'd0);
    check("rst_data", from_hw_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_sig", 32'(from_hw_sig), 32'd0);
    check("post_rst_state", 32'(dut.state),
          32'(LOAD_A));

    // Basic directed run.
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd10, 32'd20, 32'd30, 32'd40};
    full_run(1'b0);
    abort_seq();

    // Arithmetic edges, with held-valid on A[0].
    va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF,
           32'h8000_0000, $urandom};
    vb = '{32'h0000_0002, 32'h0000_0001,
           32'hFFFF_FFFF, $urandom};
    full_run(1'b1);
    abort_seq();

    // Abort after two B words, then fresh load.
    for (int i = 0; i < VLEN; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    abort_seq();
    for (int i = 0; i < VLEN; i++) begin
      va[i] = 32'd5;
      vb[i] = 32'd7;
    end
    full_run(1'b0);
    for (int i = 0; i < VLEN; i++)
      check("all12", exp_r[i], 32'd12);
    abort_seq();

    // Mid-SEND disturbance then reset pulse.
    for (int i = 0; i < VLEN; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    compute_exp();
    run_load(1'b0);
    latency_check();
    recv_one(0);
    wait_sig(ST_RVALID, "rvalid2");
    to_hw_sig = CMD_VALID;
    repeat (3) begin
      @(negedge clk);
      check("ign_sig", 32'(from_hw_sig), 32'(ST_RVALID));
      check("ign_data", from_hw_data, exp_r[1]);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_sig", 32'(from_hw_sig), 32'd0);
    check("mid_rst_data", from_hw_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    to_hw_sig = CMD_RELEASE;
    reset_n   = 1'b1;
    @(negedge clk);
    check("rerun_state", 32'(dut.state), 32'(LOAD_A));
    for (int i = 0; i < VLEN; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    full_run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
